// File: rtl/song_reader.sv
// song_reader: walks a registered-output song ROM one note at a time. Each note is handed to
// the note player with a one-cycle new_note pulse. The next note is fetched only after the
// player returns note_done.
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   play                 level: 1 = run, 0 = pause (takes effect between notes)
//   song                 song select, sampled only while idle
//   rom_addr / rom_dout  ROM address {song, index}; data arrives one cycle later
//   note, duration       current note code and duration, held while the note plays
//   new_note             one-cycle pulse: note/duration are valid
//   note_done            pulse from the note player: current note finished
//   song_done            one-cycle pulse at end of song (end marker or last index)
//   busy                 high whenever the sequencer is not idle
module song_reader #(
  parameter int unsigned SONG_BITS = 2,
  parameter int unsigned NOTE_BITS = 5
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           play,
  input  logic [SONG_BITS-1:0]           song,
  output logic [SONG_BITS+NOTE_BITS-1:0] rom_addr,
  input  logic [15:0]                    rom_dout,
  output logic [5:0]                     note,
  output logic [5:0]                     duration,
  output logic                           new_note,
  input  logic                           note_done,
  output logic                           song_done,
  output logic                           busy
);

  typedef enum logic [1:0] {StIdle, StFetch, StDecode, StWait} state_e;

  localparam logic [NOTE_BITS-1:0] LastIdx = '1;

  state_e               state_q, state_d;
  logic [SONG_BITS-1:0] song_q, song_d;
  logic [NOTE_BITS-1:0] idx_q, idx_d;
  logic [5:0]           note_q, note_d;
  logic [5:0]           duration_q, duration_d;
  logic                 new_note_q, new_note_d;
  logic                 song_done_q, song_done_d;
  logic                 busy_q, busy_d;

  logic [5:0] rom_note;
  logic [5:0] rom_dur;
  logic       unused_rom_bits;

  assign rom_note        = rom_dout[14:9];
  assign rom_dur         = rom_dout[8:3];
  assign unused_rom_bits = ^{rom_dout[15], rom_dout[2:0]};

  always_comb begin
    state_d     = state_q;
    song_d      = song_q;
    idx_d       = idx_q;
    note_d      = note_q;
    duration_d  = duration_q;
    new_note_d  = 1'b0;
    song_done_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A song change restarts at index 0 and costs one idle cycle before play is honoured.
        if (song != song_q) begin
          song_d = song;
          idx_d  = '0;
        end else if (play) begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        // The ROM captures rom_addr on this edge; its data is valid in StDecode.
        state_d = StDecode;
      end
      StDecode: begin
        if (rom_dur == 6'd0) begin
          song_done_d = 1'b1;
          idx_d       = '0;
          state_d     = StIdle;
        end else begin
          note_d     = rom_note;
          duration_d = rom_dur;
          new_note_d = 1'b1;
          state_d    = StWait;
        end
      end
      StWait: begin
        // play=0 here only stops the sequencer after the current note completes.
        if (note_done) begin
          if (idx_q == LastIdx) begin
            song_done_d = 1'b1;
            idx_d       = '0;
            state_d     = StIdle;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = play ? StFetch : StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      song_q      <= '0;
      idx_q       <= '0;
      note_q      <= '0;
      duration_q  <= '0;
      new_note_q  <= 1'b0;
      song_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      song_q      <= song_d;
      idx_q       <= idx_d;
      note_q      <= note_d;
      duration_q  <= duration_d;
      new_note_q  <= new_note_d;
      song_done_q <= song_done_d;
      busy_q      <= busy_d;
    end
  end

  assign rom_addr  = {song_q, idx_q};
  assign note      = note_q;
  assign duration  = duration_q;
  assign new_note  = new_note_q;
  assign song_done = song_done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_song_reader.sv
// Bench for song_reader: a behavioural registered ROM, a driver that plays songs through
// directed scenarios, and a scoreboard monitor that checks every new_note / song_done pulse
// against the queue of expected events.
module tb_song_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       play;
  logic [1:0] song;
  logic [6:0] rom_addr;
  logic [15:0] rom_dout;
  logic [5:0] note;
  logic [5:0] duration;
  logic       new_note;
  logic       note_done;
  logic       song_done;
  logic       busy;

  song_reader #(.SONG_BITS(2), .NOTE_BITS(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .play      (play),
    .song      (song),
    .rom_addr  (rom_addr),
    .rom_dout  (rom_dout),
    .note      (note),
    .duration  (duration),
    .new_note  (new_note),
    .note_done (note_done),
    .song_done (song_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Song ROM content as the bench intends it, plus the encoded words with junk in the
  // reserved bits.
  int          tbl_note [128];
  int          tbl_dur  [128];
  logic [15:0] rom      [128];

  always @(posedge clk) rom_dout <= rom[rom_addr];

  typedef struct packed {
    logic       is_end;
    logic [5:0] n;
    logic [5:0] d;
    logic [6:0] a;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic set_rom(input int a, input int n, input int d);
    logic [3:0] junk;
    junk       = 4'(a) ^ 4'hB;
    tbl_note[a] = n;
    tbl_dur[a]  = d;
    rom[a]      = {junk[0], 6'(n), 6'(d), junk[3:1]};
  endtask

  task automatic exp_note(input int a);
    exp_q.push_back({1'b0, 6'(tbl_note[a]), 6'(tbl_dur[a]), 7'(a)});
  endtask

  task automatic exp_end(input int a);
    exp_q.push_back({1'b1, 6'd0, 6'd0, 7'(a)});
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (new_note === 1'b1 && song_done === 1'b1) chk("excl_pulses", 32'd1, 32'd0);
    if (new_note === 1'b1 || song_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: new_note=%0b song_done=%0b addr=%0d at %0t",
                 new_note, song_done, rom_addr, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_kind", {31'd0, song_done}, {31'd0, e.is_end});
        chk("pulse_addr", {25'd0, rom_addr}, {25'd0, e.a});
        if (e.is_end) begin
          chk("busy_at_end", {31'd0, busy}, 32'd0);
        end else begin
          chk("note", {26'd0, note}, {26'd0, e.n});
          chk("duration", {26'd0, duration}, {26'd0, e.d});
          chk("busy_at_note", {31'd0, busy}, 32'd1);
        end
      end
    end
  end

  // Bounded wait for a pulse; returns on the falling edge where it is visible.
  task automatic wait_for(input bit want_end, input string name);
    int n;
    n = 0;
    while (!(want_end ? (song_done === 1'b1) : (new_note === 1'b1)) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      total++;
      bad++;
      $display("FAIL timeout_%s: got no pulse want pulse within 40 cycles", name);
    end
  endtask

  task automatic pulse_done(input int len);
    note_done = 1'b1;
    repeat (len) @(negedge clk);
    note_done = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_addr"}, {25'd0, rom_addr}, 32'd0);
    chk({tag, "_note"}, {26'd0, note}, 32'd0);
    chk({tag, "_dur"}, {26'd0, duration}, 32'd0);
    chk({tag, "_new_note"}, {31'd0, new_note}, 32'd0);
    chk({tag, "_song_done"}, {31'd0, song_done}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish by 100us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 128; i++) set_rom(i, (i * 7 + 3) % 64, (i % 63) + 1);
    set_rom(0, 49, 12);
    set_rom(1, 1, 8);
    set_rom(2, 0, 5);   // rest note
    set_rom(3, 7, 0);   // end marker with a non-zero note field

    reset     = 1'b1;
    play      = 1'b0;
    song      = 2'd0;
    note_done = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    reset = 1'b0;

    // Basic fetch, advance, rest note, end marker.
    exp_note(0);
    play = 1'b1;
    wait_for(1'b0, "note0");
    pulse_done(1);              // note_done while new_note is still high
    exp_note(1);
    wait_for(1'b0, "note1");
    repeat (2) @(negedge clk);
    pulse_done(2);              // second cycle lands in FETCH and must be ignored
    exp_note(2);
    exp_end(0);
    wait_for(1'b0, "note2");
    @(negedge clk);
    pulse_done(1);
    play = 1'b0;
    wait_for(1'b1, "end3");
    @(negedge clk);
    chk("idle_after_end_busy", {31'd0, busy}, 32'd0);
    chk("idle_after_end_addr", {25'd0, rom_addr}, 32'd0);
    pulse_done(1);              // note_done while idle is ignored
    repeat (3) @(negedge clk);
    chk("idle_done_ignored_addr", {25'd0, rom_addr}, 32'd0);
    chk("idle_done_ignored_busy", {31'd0, busy}, 32'd0);

    // Pause during note 5, resume at note 6.
    set_rom(3, 10, 3);
    play = 1'b1;
    for (int a = 0; a < 5; a++) begin
      exp_note(a);
      wait_for(1'b0, "run");
      @(negedge clk);
      pulse_done(1);
    end
    exp_note(5);
    wait_for(1'b0, "note5");
    play = 1'b0;
    repeat (2) @(negedge clk);
    chk("paused_in_wait_busy", {31'd0, busy}, 32'd1);
    pulse_done(1);
    repeat (3) @(negedge clk);
    chk("pause_addr", {25'd0, rom_addr}, 32'd6);
    chk("pause_busy", {31'd0, busy}, 32'd0);
    exp_note(6);
    play = 1'b1;
    wait_for(1'b0, "note6");

    // Song switch while busy is ignored until idle.
    song = 2'd1;
    repeat (2) @(negedge clk);
    chk("switch_busy_addr", {25'd0, rom_addr}, 32'd6);
    play = 1'b0;
    pulse_done(1);
    repeat (3) @(negedge clk);
    chk("switch_idle_addr", {25'd0, rom_addr}, 32'd32);
    set_rom(33, 21, 0);
    exp_note(32);
    exp_end(32);
    play = 1'b1;
    wait_for(1'b0, "note32");
    @(negedge clk);
    pulse_done(1);
    play = 1'b0;
    wait_for(1'b1, "end33");
    @(negedge clk);

    // Song 0 all the way to the last index.
    song = 2'd0;
    repeat (2) @(negedge clk);
    chk("back_to_song0_addr", {25'd0, rom_addr}, 32'd0);
    play = 1'b1;
    for (int a = 0; a < 32; a++) begin
      exp_note(a);
      if (a == 31) exp_end(0);
      wait_for(1'b0, "full");
      @(negedge clk);
      note_done = 1'b1;
      if (a == 31) play = 1'b0;
      @(negedge clk);
      note_done = 1'b0;
    end
    wait_for(1'b1, "last_idx");
    @(negedge clk);
    chk("last_idx_addr", {25'd0, rom_addr}, 32'd0);
    chk("last_idx_busy", {31'd0, busy}, 32'd0);

    // Reset while in DECODE: everything clears, no pulses.
    play = 1'b1;
    repeat (2) @(negedge clk);
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk_zero_outputs("mid_reset");
    reset = 1'b0;
    play  = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_reset_busy", {31'd0, busy}, 32'd0);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
